// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush controller for a 5-stage RISC-V pipeline. It combines
// the load-use hazard flag, the EX-stage branch-taken flag and the I/D-cache
// busy flags into the PC, IF/ID, ID/EX and back-end register controls.
//
// A branch resolved while the data cache freezes the pipeline is remembered
// (pend_flush) and applied exactly once when the freeze ends. A data-cache
// stall that lasts MEM_STALL_LIMIT consecutive cycles raises a sticky
// stall_timeout; the pipeline keeps waiting.
//
// Optional feature: define STALL_PERF_COUNTER_EN to build the saturating
// stall_cycles / flush_count performance counters. When it is undefined the
// ports remain but are tied to zero, and no counter flops are built.
//
// Ports:
//   CLK                  in   pipeline clock, rising edge
//   RESET                in   asynchronous active-low reset
//   hazard_detect_signal in   load-use hazard (ID vs EX)
//   branch_taken         in   EX-stage branch/jump taken, squash younger
//   icache_busy          in   instruction cache cannot deliver this cycle
//   dcache_busy          in   data cache access in MEM not complete
//   pc_write_en          out  PC update enable
//   if_id_write_en       out  IF/ID load enable
//   if_id_flush          out  load NOP into IF/ID
//   id_ex_bubble         out  load NOP into ID/EX
//   pipeline_freeze      out  hold ID/EX, EX/MEM, MEM/WB
//   stall_timeout        out  sticky runaway dcache stall flag
//   stall_cycles [31:0]  out  stall/freeze cycle count (optional feature)
//   flush_count  [31:0]  out  applied flush count (optional feature)
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int CNT_W           = 8,
  parameter int MEM_STALL_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        hazard_detect_signal,
  input  logic        branch_taken,
  input  logic        icache_busy,
  input  logic        dcache_busy,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipeline_freeze,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_STALL,
    ST_MEM_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pend_flush;
  logic             w_pend_next;
  logic [CNT_W-1:0] r_mem_cnt;
  logic [CNT_W-1:0] w_mem_cnt_next;
  logic             r_stall_timeout;

  // Priority decode: dcache freeze > flush > load-use stall > icache miss > run.
  // MEM_WAIT needs no dedicated branch: once dcache_busy drops, the same
  // flush/stall/run rules apply as from RUN.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so that no
    // path leaves a variable unassigned, which would infer a latch.
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    pipeline_freeze = 1'b0;
    w_state_next    = ST_RUN;
    w_pend_next     = r_pend_flush;

    if (!RESET) begin
      // Hold the front end and keep NOPs flowing while reset is asserted.
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
    end else if (dcache_busy) begin
      pipeline_freeze = 1'b1;
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      w_state_next    = ST_MEM_WAIT;
      // Any number of branches during one freeze collapse into one flush.
      if (branch_taken) w_pend_next = 1'b1;
    end else if (branch_taken || r_pend_flush) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      w_pend_next  = 1'b0;
    end else if (hazard_detect_signal && (r_state != ST_LOAD_STALL)) begin
      // A hazard still seen in LOAD_STALL is spurious: the bubble already
      // separated the load from its consumer.
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
      w_state_next   = ST_LOAD_STALL;
    end else if (icache_busy) begin
      pc_write_en = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Saturating consecutive dcache-stall counter; any idle cycle clears it.
  always_comb begin
    w_mem_cnt_next = '0;
    if (dcache_busy) begin
      w_mem_cnt_next = (r_mem_cnt == {CNT_W{1'b1}}) ? r_mem_cnt : r_mem_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state         <= ST_RUN;
      r_pend_flush    <= 1'b0;
      r_mem_cnt       <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_state      <= w_state_next;
      r_pend_flush <= w_pend_next;
      r_mem_cnt    <= w_mem_cnt_next;
      if (dcache_busy && (w_mem_cnt_next == CNT_W'(MEM_STALL_LIMIT))) begin
        r_stall_timeout <= 1'b1;
      end
    end
  end

  assign stall_timeout = r_stall_timeout;

`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // A flush cycle is the only one with both if_id_flush and pc_write_en high:
  // the icache-miss flush holds the PC and reset forces pc_write_en low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((!pc_write_en || pipeline_freeze) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (if_id_flush && pc_write_en && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Directed bench for pipeline_stall_controller with MEM_STALL_LIMIT=10.
// Inputs change on the falling edge; combinational outputs are sampled 1 time
// unit later, well away from the rising edge that commits state.
// Input vectors are packed {hazard, branch, icache, dcache}; output vectors
// are packed {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, freeze}.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

`ifdef STALL_PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [4:0] O_RESET = 5'b00110;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_LOAD  = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_ICM   = 5'b01100;
  localparam logic [4:0] O_FRZ   = 5'b00001;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        hazard_detect_signal = 1'b0;
  logic        branch_taken = 1'b0;
  logic        icache_busy = 1'b0;
  logic        dcache_busy = 1'b0;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        pipeline_freeze;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [4:0]  outs;

  int checks = 0;
  int errors = 0;

  pipeline_stall_controller #(
    .CNT_W          (8),
    .MEM_STALL_LIMIT(10)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .hazard_detect_signal(hazard_detect_signal),
    .branch_taken        (branch_taken),
    .icache_busy         (icache_busy),
    .dcache_busy         (dcache_busy),
    .pc_write_en         (pc_write_en),
    .if_id_write_en      (if_id_write_en),
    .if_id_flush         (if_id_flush),
    .id_ex_bubble        (id_ex_bubble),
    .pipeline_freeze     (pipeline_freeze),
    .stall_timeout       (stall_timeout),
    .stall_cycles        (stall_cycles),
    .flush_count         (flush_count)
  );

  always #5 CLK = ~CLK;

  assign outs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pipeline_freeze};

  task automatic drive(input logic [3:0] v);
    @(negedge CLK);
    {hazard_detect_signal, branch_taken, icache_busy, dcache_busy} = v;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    {hazard_detect_signal, branch_taken, icache_busy, dcache_busy} = 4'b0000;
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RESET);
    end
    checks++;
    if ({stall_timeout, stall_cycles, flush_count} !== 65'd0) begin
      errors++; $display("FAIL reset_state got=%b/%0d/%0d exp=0/0/0", stall_timeout, stall_cycles, flush_count);
    end
    // Inputs that would otherwise freeze or flush are overridden by reset.
    {branch_taken, dcache_busy} = 2'b11;
    #1;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL reset_override got=%b exp=%b", outs, O_RESET);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    logic [3:0] vin [0:2];
    logic [4:0] vexp [0:2];
    vin  = '{4'b1000, 4'b1000, 4'b0000};
    vexp = '{O_LOAD, O_RUN, O_RUN};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(vin[i]);
      checks++;
      if (outs !== vexp[i]) begin
        errors++; $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, vexp[i]);
      end
    end
  endtask

  task automatic test_branch_hazard();
    // A hazard right after the flush must stall again: proves no LOAD_STALL.
    logic [3:0] vin [0:3];
    logic [4:0] vexp [0:3];
    vin  = '{4'b1100, 4'b1000, 4'b1000, 4'b0000};
    vexp = '{O_FLUSH, O_LOAD, O_RUN, O_RUN};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vin[i]);
      checks++;
      if (outs !== vexp[i]) begin
        errors++; $display("FAIL branch_hazard[%0d] got=%b exp=%b", i, outs, vexp[i]);
      end
    end
  endtask

  task automatic test_deferred_flush();
    // 4 busy cycles with a branch in cycle 2, then two branches in one freeze
    // followed by an icache miss that the pending flush overrides.
    logic [3:0] vin [0:10];
    logic [4:0] vexp [0:10];
    vin  = '{4'b0001, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
             4'b0101, 4'b0001, 4'b0101, 4'b0010, 4'b0000};
    vexp = '{O_FRZ, O_FRZ, O_FRZ, O_FRZ, O_FLUSH, O_RUN,
             O_FRZ, O_FRZ, O_FRZ, O_FLUSH, O_RUN};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vin[i]);
      checks++;
      if (outs !== vexp[i]) begin
        errors++; $display("FAIL deferred_flush[%0d] got=%b exp=%b", i, outs, vexp[i]);
      end
      if (i == 5) begin
        checks++;
        if (flush_count !== (PERF ? 32'd1 : 32'd0) || stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin
          errors++; $display("FAIL deferred_counts got=%0d/%0d exp=%0d/%0d", flush_count, stall_cycles,
                             PERF ? 1 : 0, PERF ? 4 : 0);
        end
      end
    end
    checks++;
    if (flush_count !== (PERF ? 32'd2 : 32'd0) || stall_cycles !== (PERF ? 32'd7 : 32'd0)) begin
      errors++; $display("FAIL multi_branch_counts got=%0d/%0d exp=%0d/%0d", flush_count, stall_cycles,
                         PERF ? 2 : 0, PERF ? 7 : 0);
    end
  endtask

  task automatic test_icache_miss();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010);
      checks++;
      if (outs !== O_ICM) begin
        errors++; $display("FAIL icache[%0d] got=%b exp=%b", i, outs, O_ICM);
      end
    end
    drive(4'b0000);
    checks++;
    if (outs !== O_RUN || stall_cycles !== (PERF ? 32'd3 : 32'd0) || flush_count !== 32'd0) begin
      errors++; $display("FAIL icache_after got=%b/%0d/%0d exp=%b/%0d/0", outs, stall_cycles, flush_count,
                         O_RUN, PERF ? 3 : 0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    // During busy cycle i (1-based), i-1 busy edges have passed; the flag
    // rises on the 10th edge, so it reads 1 from cycle 11 on.
    for (int i = 1; i <= 12; i++) begin
      drive(4'b0001);
      checks++;
      if (stall_timeout !== (i >= 11) || outs !== O_FRZ) begin
        errors++; $display("FAIL timeout[%0d] got=%b/%b exp=%b/%b", i, stall_timeout, outs, (i >= 11), O_FRZ);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000);
      checks++;
      if (stall_timeout !== 1'b1 || outs !== O_RUN) begin
        errors++; $display("FAIL timeout_sticky[%0d] got=%b/%b exp=1/%b", i, stall_timeout, outs, O_RUN);
      end
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_reset got=%b exp=0", stall_timeout);
    end
    RESET = 1'b1;
    // Two 9-cycle stalls separated by one idle cycle never reach the limit.
    for (int i = 0; i < 19; i++) begin
      drive((i == 9) ? 4'b0000 : 4'b0001);
      checks++;
      if (stall_timeout !== 1'b0) begin
        errors++; $display("FAIL timeout_clear[%0d] got=%b exp=0", i, stall_timeout);
      end
    end
    drive(4'b0000);
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear_end got=%b exp=0", stall_timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(4'b0101);
    drive(4'b0001);
    checks++;
    if (outs !== O_FRZ) begin
      errors++; $display("FAIL async_pre got=%b exp=%b", outs, O_FRZ);
    end
    #1;
    RESET = 1'b0;
    #1;
    checks++;
    if (outs !== O_RESET || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL async_assert got=%b/%0d/%0d exp=%b/0/0", outs, stall_cycles, flush_count, O_RESET);
    end
    @(negedge CLK);
    {hazard_detect_signal, branch_taken, icache_busy, dcache_busy} = 4'b0000;
    RESET = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (outs !== O_RUN || flush_count !== 32'd0) begin
        errors++; $display("FAIL async_release[%0d] got=%b/%0d exp=%b/0", i, outs, flush_count, O_RUN);
      end
      drive(4'b0000);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_hazard();
    test_deferred_flush();
    test_icache_miss();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
